ssd_scan_mux: RTL and testbench



---
 rtl/ssd_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 39 +++
 rtl/ssd_scan_mux.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_mux.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Segment codes are active-low, laid out as bit7..bit1 = a..g and bit0 = dp.
// Every code keeps bit0 = 1 (dp dark); the decimal point is applied separately.
package ssd_pkg;

  localparam logic [7:0] SEG_0    = 8'b0000_0011;
  localparam logic [7:0] SEG_1    = 8'b1001_1111;
  localparam logic [7:0] SEG_2    = 8'b0010_0101;
  localparam logic [7:0] SEG_3    = 8'b0000_1101;
  localparam logic [7:0] SEG_4    = 8'b1001_1001;
  localparam logic [7:0] SEG_5    = 8'b0100_1001;
  localparam logic [7:0] SEG_6    = 8'b0100_0001;
  localparam logic [7:0] SEG_7    = 8'b0001_1111;
  localparam logic [7:0] SEG_8    = 8'b0000_0001;
  localparam logic [7:0] SEG_9    = 8'b0000_1001;
  localparam logic [7:0] SEG_A    = 8'b0001_0001;
  localparam logic [7:0] SEG_B    = 8'b1100_0001;
  localparam logic [7:0] SEG_C    = 8'b0110_0011;
  localparam logic [7:0] SEG_D    = 8'b1000_0101;
  localparam logic [7:0] SEG_E    = 8'b0110_0001;
  localparam logic [7:0] SEG_F    = 8'b0111_0001;
  localparam logic [7:0] SEG_DFLT = 8'b0111_0001;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to seven-segment decoder (segments a..g only, active-low).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   nibble   in  4  value to display
//   hex_mode in  1  1 = letters A b C d E F for 10..15, 0 = all show F
//   seg      out 7  active-low segments, seg[7..1] = a..g
module seg7_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [7:1] seg
);

  always_comb begin
    seg = SEG_DFLT[7:1];
    case (nibble)
      4'h0: seg = SEG_0[7:1];
      4'h1: seg = SEG_1[7:1];
      4'h2: seg = SEG_2[7:1];
      4'h3: seg = SEG_3[7:1];
      4'h4: seg = SEG_4[7:1];
      4'h5: seg = SEG_5[7:1];
      4'h6: seg = SEG_6[7:1];
      4'h7: seg = SEG_7[7:1];
      4'h8: seg = SEG_8[7:1];
      4'h9: seg = SEG_9[7:1];
      4'hA: seg = hex_mode ? SEG_A[7:1] : SEG_DFLT[7:1];
      4'hB: seg = hex_mode ? SEG_B[7:1] : SEG_DFLT[7:1];
      4'hC: seg = hex_mode ? SEG_C[7:1] : SEG_DFLT[7:1];
      4'hD: seg = hex_mode ? SEG_D[7:1] : SEG_DFLT[7:1];
      4'hE: seg = hex_mode ? SEG_E[7:1] : SEG_DFLT[7:1];
      4'hF: seg = SEG_F[7:1];
    endcase
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// N-digit time-multiplexed seven-segment driver with frame-coherent input snapshot.
// Latency: outputs are registered, one cycle behind the scan index and shadow state.
// Backpressure: none; free-running scan, inputs are sampled only at frame boundaries.
//
// Ports:
//   clk       in  1            system clock
//   rst_n     in  1            synchronous active-low reset
//   digits    in  4*N_DIGITS   nibble i = digits[4i+3:4i], digit 0 is rightmost
//   dp_in     in  N_DIGITS     1 = light decimal point of digit i
//   blank     in  N_DIGITS     1 = force digit i dark (anode still scanned)
//   hex_mode  in  1            1 = show 10..15 as letters
//   lzs       in  1            1 = leading-zero suppression
//   ssd_ctl   out N_DIGITS     one-cold anode enables, active-low
//   segs      out 8            active-low segments, bit7..1 = a..g, bit0 = dp
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  hex_mode,
  input  logic                  lzs,
  output logic [N_DIGITS-1:0]   ssd_ctl,
  output logic [7:0]            segs
);

  localparam int PRE_W = clog2(REFRESH_DIV);
  localparam int IDX_W = clog2(N_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]      r_pre_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_load_pend;

  // Shadow copy of the display inputs, held constant for a whole frame.
  logic [4*N_DIGITS-1:0] r_digits_s;
  logic [N_DIGITS-1:0]   r_dp_s;
  logic [N_DIGITS-1:0]   r_blank_s;
  logic                  r_hex_s;
  logic                  r_lzs_s;

  logic [N_DIGITS-1:0]   r_ssd_ctl;
  logic [7:0]            r_segs;

  logic                  w_tick;
  logic                  w_snap;
  logic [3:0]            w_nibble;
  logic                  w_blank_cur;
  logic                  w_dp_cur;
  logic                  w_lz_cur;
  logic [N_DIGITS-1:0]   w_anode;
  logic [7:1]            w_dec;
  logic [7:0]            w_segs;

  assign w_tick = (r_pre_cnt == PRE_LAST);

  // Snapshot once right after reset, then only as the last digit hands back
  // to digit 0, so a frame never mixes old and new input values.
  assign w_snap = r_load_pend || (w_tick && (r_idx == IDX_LAST));

  // Select the current digit's fields. The zero-run flag walks from the MSD
  // down, so at digit i it is set only when nibbles i..N-1 are all zero.
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    w_nibble    = 4'h0;
    w_blank_cur = 1'b0;
    w_dp_cur    = 1'b0;
    w_lz_cur    = 1'b0;
    w_anode     = '1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (r_digits_s[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_digits_s[4*i +: 4];
        w_blank_cur = r_blank_s[i];
        w_dp_cur    = r_dp_s[i];
        w_lz_cur    = zero_run && (i != 0);
        w_anode[i]  = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble   (w_nibble),
    .hex_mode (r_hex_s),
    .seg      (w_dec)
  );

  // Blank wins over suppression, which wins over the decoded glyph; the
  // decimal point is independent of all three.
  always_comb begin
    w_segs[0] = ~w_dp_cur;
    if (w_blank_cur) begin
      w_segs[7:1] = SEG_OFF[7:1];
    end else if (r_lzs_s && w_lz_cur) begin
      w_segs[7:1] = SEG_OFF[7:1];
    end else begin
      w_segs[7:1] = w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt   <= '0;
      r_idx       <= '0;
      r_load_pend <= 1'b1;
      r_digits_s  <= '0;
      r_dp_s      <= '0;
      r_blank_s   <= '1;
      r_hex_s     <= 1'b0;
      r_lzs_s     <= 1'b0;
      r_ssd_ctl   <= '1;
      r_segs      <= SEG_OFF;
    end else begin
      if (w_tick) begin
        r_pre_cnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end

      if (w_snap) begin
        r_digits_s <= digits;
        r_dp_s     <= dp_in;
        r_blank_s  <= blank;
        r_hex_s    <= hex_mode;
        r_lzs_s    <= lzs;
      end
      r_load_pend <= 1'b0;

      r_ssd_ctl <= w_anode;
      r_segs    <= w_segs;
    end
  end

  assign ssd_ctl = r_ssd_ctl;
  assign segs    = r_segs;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux: table vectors, hand sequences,
// randomized run against a frame-level reference model, and a wide-scan check.
module tb_ssd_scan_mux;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int N8   = 8;
  localparam int DIV8 = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        hex_mode;
  logic        lzs;
  logic [3:0]  ssd_ctl;
  logic [7:0]  segs;

  logic [31:0] digits8;
  logic [7:0]  dp8;
  logic [7:0]  blank8;
  logic [7:0]  ctl8;
  logic [7:0]  segs8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ssd_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .dp_in    (dp_in),
    .blank    (blank),
    .hex_mode (hex_mode),
    .lzs      (lzs),
    .ssd_ctl  (ssd_ctl),
    .segs     (segs)
  );

  ssd_scan_mux #(.N_DIGITS(N8), .REFRESH_DIV(DIV8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits8),
    .dp_in    (dp8),
    .blank    (blank8),
    .hex_mode (hex_mode),
    .lzs      (lzs),
    .ssd_ctl  (ctl8),
    .segs     (segs8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Glyph table written straight from the segment code list.
  function automatic logic [7:0] glyph(input logic [3:0] nib, input logic hx);
    case (nib)
      4'd0:  return 8'h03;
      4'd1:  return 8'h9F;
      4'd2:  return 8'h25;
      4'd3:  return 8'h0D;
      4'd4:  return 8'h99;
      4'd5:  return 8'h49;
      4'd6:  return 8'h41;
      4'd7:  return 8'h1F;
      4'd8:  return 8'h01;
      4'd9:  return 8'h09;
      4'd10: return hx ? 8'h11 : 8'h71;
      4'd11: return hx ? 8'hC1 : 8'h71;
      4'd12: return hx ? 8'h63 : 8'h71;
      4'd13: return hx ? 8'h85 : 8'h71;
      4'd14: return hx ? 8'h61 : 8'h71;
      default: return 8'h71;
    endcase
  endfunction

  // What digit i of a frame should look like, from the display rules.
  function automatic logic [7:0] ref_pat(input logic [15:0] d, input logic [3:0] dp,
                                         input logic [3:0] bl, input logic hx,
                                         input logic lz, input int i);
    logic [7:0]  p;
    logic [15:0] hi;
    p  = glyph(d[4*i +: 4], hx);
    hi = d >> (4 * i);
    if (bl[i] || (lz && i > 0 && hi == 16'h0)) p[7:1] = 7'h7F;
    p[0] = ~dp[i];
    return p;
  endfunction

  // Frame-level reference: m_n counts released edges; the digit shown is
  // (m_n / DIV) mod N; the frame contents are whatever inputs were present at
  // the first released edge or at the edge that closes each frame.
  int          m_n;
  logic        m_has;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_bl;
  logic        m_hx, m_lz;
  logic [3:0]  exp_ctl;
  logic [7:0]  exp_segs;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n      <= 0;
      m_has    <= 1'b0;
      exp_ctl  <= 4'hF;
      exp_segs <= 8'hFF;
    end else begin
      exp_ctl  <= ~(4'b0001 << ((m_n / DIV) % N));
      exp_segs <= m_has ? ref_pat(m_dig, m_dp, m_bl, m_hx, m_lz, (m_n / DIV) % N) : 8'hFF;
      if (m_n == 0 || ((m_n % DIV) == DIV - 1 && (m_n / DIV) % N == N - 1)) begin
        m_dig <= digits;
        m_dp  <= dp_in;
        m_bl  <= blank;
        m_hx  <= hex_mode;
        m_lz  <= lzs;
        m_has <= 1'b1;
      end
      m_n <= m_n + 1;
    end
  end

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      bl;
    logic            hx;
    logic            lz;
    logic [3:0][7:0] exp;   // exp[d] = segs while digit d is lit
  } vec_t;

  vec_t vecs[9];

  task automatic apply(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                       input logic hx, input logic lz);
    digits = d; dp_in = dp; blank = bl; hex_mode = hx; lzs = lz;
  endtask

  // Pulse reset for one edge; returns at the negedge after the reset edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ectl;
    logic [7:0] prev8;
    int run, last_fe, bad_cold;

    vecs[0] = '{16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, {8'h99, 8'h0D, 8'h25, 8'h9F}};
    vecs[1] = '{16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0, {8'h71, 8'h71, 8'h71, 8'h71}};
    vecs[2] = '{16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0, {8'h71, 8'h61, 8'h85, 8'h11}};
    vecs[3] = '{16'h0070, 4'h4, 4'h1, 1'b0, 1'b1, {8'hFF, 8'hFE, 8'h1F, 8'hFF}};
    vecs[4] = '{16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[5] = '{16'h8B9C, 4'hF, 4'h0, 1'b1, 1'b0, {8'h00, 8'hC0, 8'h08, 8'h62}};
    vecs[6] = '{16'h1005, 4'h0, 4'h0, 1'b0, 1'b1, {8'h9F, 8'h03, 8'h03, 8'h49}};
    vecs[7] = '{16'h0500, 4'h0, 4'h0, 1'b0, 1'b1, {8'hFF, 8'h49, 8'h03, 8'h03}};
    vecs[8] = '{16'h9999, 4'h8, 4'hA, 1'b0, 1'b0, {8'hFE, 8'h09, 8'hFF, 8'h09}};

    rst_n = 1'b0;
    apply(16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    digits8 = 32'h0000_0012; dp8 = 8'h00; blank8 = 8'h00;
    repeat (3) @(negedge clk);

    // Table vectors: reset, then visit each digit slot of the first frame.
    for (int v = 0; v < 9; v++) begin
      apply(vecs[v].dig, vecs[v].dp, vecs[v].bl, vecs[v].hx, vecs[v].lz);
      rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d reset ctl", v), ssd_ctl, 4'hF);
      chk($sformatf("v%0d reset segs", v), segs, 8'hFF);
      rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d edge1 ctl", v), ssd_ctl, 4'hE);
      chk($sformatf("v%0d edge1 segs", v), segs, 8'hFF);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        ectl = ~(4'b0001 << d);
        chk($sformatf("v%0d d%0d ctl", v, d), ssd_ctl, ectl);
        chk($sformatf("v%0d d%0d segs", v, d), segs, vecs[v].exp[d]);
        repeat (4) @(negedge clk);
      end
    end

    // Frame coherence: change inputs while digit 1 is lit.
    apply(16'h1111, 4'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    repeat (6) @(negedge clk);
    digits = 16'h2222;
    chk("coh d1", segs, 8'h9F);
    repeat (4) @(negedge clk);
    chk("coh d2", segs, 8'h9F);
    repeat (4) @(negedge clk);
    chk("coh d3", segs, 8'h9F);
    repeat (4) @(negedge clk);
    chk("coh next d0 ctl", ssd_ctl, 4'hE);
    chk("coh next d0", segs, 8'h25);

    // Hex mode takes effect only from the next frame.
    apply(16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    repeat (6) @(negedge clk);
    hex_mode = 1'b1;
    repeat (4) @(negedge clk);
    chk("hex old d2", segs, 8'h71);
    repeat (8) @(negedge clk);
    chk("hex new d0", segs, 8'h11);
    repeat (4) @(negedge clk);
    chk("hex new d1", segs, 8'h85);

    // Reset while digit 2 is lit.
    apply(16'h4321, 4'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    repeat (10) @(negedge clk);
    chk("mid d2 ctl", ssd_ctl, 4'hB);
    chk("mid d2 segs", segs, 8'h0D);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst ctl", ssd_ctl, 4'hF);
    chk("mid rst segs", segs, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rel1 segs", segs, 8'hFF);
    @(negedge clk);
    chk("mid rel2 ctl", ssd_ctl, 4'hE);
    chk("mid rel2 segs", segs, 8'h9F);

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blank = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 19) == 0) hex_mode = 1'($urandom);
      if ($urandom_range(0, 19) == 0) lzs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) digits = digits & 16'h00FF;
      rst_n = ($urandom_range(0, 299) != 0);
      @(negedge clk);
      chk($sformatf("rnd %0d ctl", c), ssd_ctl, exp_ctl);
      chk($sformatf("rnd %0d segs", c), segs, exp_segs);
    end

    // Eight-digit scan: dwell time, order, one-cold and frame period.
    lzs = 1'b1; hex_mode = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("w8 edge1 ctl", ctl8, 8'hFE);
    prev8 = ctl8; run = 1; last_fe = 1; bad_cold = 0;
    for (int c = 2; c <= 2 * N8 * DIV8 + 10; c++) begin
      @(negedge clk);
      if ($countones(~ctl8) != 1) bad_cold++;
      if (c == 2)   chk("w8 d0 segs", segs8, 8'h25);
      if (c == 700) chk("w8 d1 segs", segs8, 8'h9F);
      if (c == 1200) chk("w8 d2 supp", segs8, 8'hFF);
      if (ctl8 == prev8) begin
        run++;
      end else begin
        chk($sformatf("w8 dwell@%0d", c), run, DIV8);
        chk($sformatf("w8 order@%0d", c), ctl8, {prev8[6:0], prev8[7]});
        if (ctl8 == 8'hFE) begin
          chk($sformatf("w8 period@%0d", c), c - last_fe, N8 * DIV8);
          last_fe = c;
        end
        prev8 = ctl8;
        run = 1;
      end
    end
    chk("w8 onecold", bad_cold, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
